synth_voice: RTL and testbench

Single parametrised synthesizer voice: a phase-accumulator oscillator with selectable waveform, shaped by a gate-driven ADSR envelope, scaled by a 16-bit amplitude word and converted to a 1-bit PDM stream for the audio pin. It is the successor to the fixed sine/saw voice, with a generic sample width, runtime pitch and waveform, and a real envelope in place of the free-running modulator. Multiple instances are summed at top level for polyphony.

---
 rtl/synth_pkg.sv | 27 ++
 rtl/adsr_env.sv | 141 ++++++++++++++
 rtl/synth_voice.sv | 102 ++++++++++
 tb/tb_synth_voice.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared types and constants for the synthesizer voice and its envelope generator.
package synth_pkg;

    typedef enum logic [2:0] {
        EG_IDLE    = 3'd0,
        EG_ATTACK  = 3'd1,
        EG_DECAY   = 3'd2,
        EG_SUSTAIN = 3'd3,
        EG_RELEASE = 3'd4
    } eg_state_t;

    localparam logic [1:0] WAVE_SAW    = 2'd0;
    localparam logic [1:0] WAVE_SQUARE = 2'd1;
    localparam logic [1:0] WAVE_TRI    = 2'd2;
    localparam logic [1:0] WAVE_NOISE  = 2'd3;

    // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] state);
        logic [15:0] shifted;
        shifted = state >> 1;
        return state[0] ? (shifted ^ LFSR_TAPS) : shifted;
    endfunction

endpackage

// File: rtl/adsr_env.sv
// Gate-driven ADSR envelope: gate synchroniser, update-tick counter, state machine and level register.
//   state   | meaning
//   IDLE    | silent, level held at 0
//   ATTACK  | rising by attack_step per tick until full scale
//   DECAY   | falling by decay_step per tick down to sustain_lvl
//   SUSTAIN | level follows sustain_lvl
//   RELEASE | falling by release_step per tick down to 0
module adsr_env
    import synth_pkg::*;
#(
    parameter int ENV_W    = 16,
    parameter int ENV_TICK = 5_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gate,
    input  logic [ENV_W-1:0] attack_step,
    input  logic [ENV_W-1:0] decay_step,
    input  logic [ENV_W-1:0] release_step,
    input  logic [ENV_W-1:0] sustain_lvl,
    output logic [ENV_W-1:0] env_level,
    output eg_state_t        eg_state,
    output logic             busy
);

    localparam int TICK_W = $clog2(ENV_TICK);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(ENV_TICK - 1);
    localparam logic [ENV_W-1:0]  LVL_MAX   = '1;

    if (ENV_TICK < 2) begin : g_env_tick_too_small
        $error("adsr_env: ENV_TICK must be at least 2");
    end

    logic              gate_meta;
    logic              gs;
    logic              gs_d;
    logic              rise;
    logic              fall;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic [ENV_W:0]    atk_sum;
    logic [ENV_W:0]    dec_diff;
    logic [ENV_W:0]    rel_diff;
    logic              atk_top;
    logic              dec_floor;
    logic              rel_floor;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_meta <= 1'b0;
            gs        <= 1'b0;
            gs_d      <= 1'b0;
        end else begin
            gate_meta <= gate;
            gs        <= gate_meta;
            gs_d      <= gs;
        end
    end

    assign rise = gs & ~gs_d;
    assign fall = ~gs & gs_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick = (tick_cnt == TICK_LAST);

    // One extra bit catches overflow past full scale and underflow below zero.
    assign atk_sum  = {1'b0, env_level} + {1'b0, attack_step};
    assign dec_diff = {1'b0, env_level} - {1'b0, decay_step};
    assign rel_diff = {1'b0, env_level} - {1'b0, release_step};

    assign atk_top   = (attack_step == '0) || (atk_sum >= {1'b0, LVL_MAX});
    assign dec_floor = (decay_step == '0) || dec_diff[ENV_W]
                       || (dec_diff[ENV_W-1:0] <= sustain_lvl);
    assign rel_floor = (release_step == '0) || rel_diff[ENV_W]
                       || (rel_diff[ENV_W-1:0] == '0);

    // A gate edge takes priority over a coincident tick; that tick's step is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eg_state  <= EG_IDLE;
            env_level <= '0;
            busy      <= 1'b0;
        end else if (rise) begin
            eg_state <= EG_ATTACK;
            busy     <= 1'b1;
        end else if (fall) begin
            if (eg_state == EG_ATTACK || eg_state == EG_DECAY || eg_state == EG_SUSTAIN) begin
                eg_state <= EG_RELEASE;
            end
        end else if (tick) begin
            case (eg_state)
                EG_IDLE: begin
                    env_level <= '0;
                end
                EG_ATTACK: begin
                    if (atk_top) begin
                        env_level <= LVL_MAX;
                        eg_state  <= EG_DECAY;
                    end else begin
                        env_level <= atk_sum[ENV_W-1:0];
                    end
                end
                EG_DECAY: begin
                    if (dec_floor) begin
                        env_level <= sustain_lvl;
                        eg_state  <= EG_SUSTAIN;
                    end else begin
                        env_level <= dec_diff[ENV_W-1:0];
                    end
                end
                EG_SUSTAIN: begin
                    env_level <= sustain_lvl;
                end
                EG_RELEASE: begin
                    if (rel_floor) begin
                        env_level <= '0;
                        eg_state  <= EG_IDLE;
                        busy      <= 1'b0;
                    end else begin
                        env_level <= rel_diff[ENV_W-1:0];
                    end
                end
                default: begin
                    env_level <= '0;
                    eg_state  <= EG_IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/synth_voice.sv
// One synthesizer voice: phase-accumulator oscillator, ADSR-shaped and gain-scaled,
// delivered as a first-order PDM bitstream.
module synth_voice
    import synth_pkg::*;
#(
    parameter int CLKSPEED = 50_000_000,
    parameter int W        = 10,
    parameter int PHASE_W  = 24,
    parameter int ENV_W    = 16,
    parameter int ENV_TICK = 5_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               gate,
    input  logic [PHASE_W-1:0] phase_inc,
    input  logic [1:0]         wave_sel,
    input  logic [ENV_W-1:0]   attack_step,
    input  logic [ENV_W-1:0]   decay_step,
    input  logic [ENV_W-1:0]   release_step,
    input  logic [ENV_W-1:0]   sustain_lvl,
    input  logic [15:0]        amp_in,
    output logic [W-1:0]       sample,
    output logic [ENV_W-1:0]   env_level,
    output eg_state_t          eg_state,
    output logic               busy,
    output logic               dout
);

    if (CLKSPEED <= 0 || W < 2 || W > 16 || PHASE_W < W) begin : g_bad_params
        $error("synth_voice: need CLKSPEED > 0, 2 <= W <= 16 and PHASE_W >= W");
    end

    logic [PHASE_W-1:0]   acc;
    logic [PHASE_W:0]     acc_sum;
    logic [W-1:0]         p;
    logic [15:0]          lfsr;
    logic [W-1:0]         wave_nxt;
    logic [W-1:0]         wave;
    logic [W-1:0]         m1;
    logic [W+ENV_W-1:0]   prod_env;
    logic [W+15:0]        prod_amp;
    logic [W:0]           pdm_sum;
    logic [W-1:0]         err;

    adsr_env #(
        .ENV_W    (ENV_W),
        .ENV_TICK (ENV_TICK)
    ) u_env (
        .clk          (clk),
        .rst          (rst),
        .gate         (gate),
        .attack_step  (attack_step),
        .decay_step   (decay_step),
        .release_step (release_step),
        .sustain_lvl  (sustain_lvl),
        .env_level    (env_level),
        .eg_state     (eg_state),
        .busy         (busy)
    );

    // The carry out of the accumulator marks a phase wrap and clocks the noise source.
    assign acc_sum = {1'b0, acc} + {1'b0, phase_inc};
    assign p       = acc[PHASE_W-1 -: W];

    always_comb begin
        wave_nxt = '0;
        case (wave_sel)
            WAVE_SAW:    wave_nxt = p;
            WAVE_SQUARE: wave_nxt = {W{p[W-1]}};
            WAVE_TRI:    wave_nxt = p[W-1] ? ~{p[W-2:0], 1'b0} : {p[W-2:0], 1'b0};
            WAVE_NOISE:  wave_nxt = lfsr[15 -: W];
            default:     wave_nxt = '0;
        endcase
    end

    assign prod_env = {{ENV_W{1'b0}}, wave} * {{W{1'b0}}, env_level};
    assign prod_amp = {16'b0, m1} * {{W{1'b0}}, amp_in};
    assign pdm_sum  = {1'b0, err} + {1'b0, sample};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            lfsr   <= LFSR_SEED;
            wave   <= '0;
            m1     <= '0;
            sample <= '0;
            err    <= '0;
            dout   <= 1'b0;
        end else begin
            acc <= acc_sum[PHASE_W-1:0];
            if (acc_sum[PHASE_W]) begin
                lfsr <= lfsr_next(lfsr);
            end
            wave   <= wave_nxt;
            m1     <= W'(prod_env >> ENV_W);
            sample <= W'(prod_amp >> 16);
            dout   <= pdm_sum[W];
            err    <= pdm_sum[W-1:0];
        end
    end

endmodule

// File: tb/tb_synth_voice.sv
// Self-checking bench for synth_voice: envelope vector table, hand-written corner sequences,
// and randomized oscillator/scaling segments checked against an arithmetic reference model.
module tb_synth_voice;
    import synth_pkg::*;

    localparam int W        = 10;
    localparam int PHASE_W  = 24;
    localparam int ENV_W    = 16;
    localparam int ENV_TICK = 4;
    localparam longint PHASE_MOD = 64'd16777216;

    logic               clk = 1'b0;
    logic               rst;
    logic               gate;
    logic [PHASE_W-1:0] phase_inc;
    logic [1:0]         wave_sel;
    logic [ENV_W-1:0]   attack_step;
    logic [ENV_W-1:0]   decay_step;
    logic [ENV_W-1:0]   release_step;
    logic [ENV_W-1:0]   sustain_lvl;
    logic [15:0]        amp_in;
    logic [W-1:0]       sample;
    logic [ENV_W-1:0]   env_level;
    eg_state_t          eg_state;
    logic               busy;
    logic               dout;

    always #5 clk = ~clk;

    synth_voice #(
        .CLKSPEED (50_000_000),
        .W        (W),
        .PHASE_W  (PHASE_W),
        .ENV_W    (ENV_W),
        .ENV_TICK (ENV_TICK)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .gate         (gate),
        .phase_inc    (phase_inc),
        .wave_sel     (wave_sel),
        .attack_step  (attack_step),
        .decay_step   (decay_step),
        .release_step (release_step),
        .sustain_lvl  (sustain_lvl),
        .amp_in       (amp_in),
        .sample       (sample),
        .env_level    (env_level),
        .eg_state     (eg_state),
        .busy         (busy),
        .dout         (dout)
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference oscillator: phase as a plain integer mod 2^24, noise register stepped on each wrap.
    longint      m_acc;
    logic [15:0] m_lfsr;
    longint      acc_h [3];
    logic [15:0] lfsr_h [3];
    int          ecount;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic [15:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_acc  <= 0;
            m_lfsr <= 16'hACE1;
            ecount <= 0;
            for (int i = 0; i < 3; i++) begin
                acc_h[i]  <= 0;
                lfsr_h[i] <= 16'hACE1;
            end
        end else begin
            m_acc <= (m_acc + longint'(phase_inc)) % PHASE_MOD;
            if (m_acc + longint'(phase_inc) >= PHASE_MOD) m_lfsr <= lfsr_step(m_lfsr);
            acc_h[0]  <= m_acc;
            acc_h[1]  <= acc_h[0];
            acc_h[2]  <= acc_h[1];
            lfsr_h[0] <= m_lfsr;
            lfsr_h[1] <= lfsr_h[0];
            lfsr_h[2] <= lfsr_h[1];
            ecount    <= ecount + 1;
        end
    end

    function automatic longint exp_sample(input longint acc, input logic [15:0] l, input int ws,
                                          input longint env, input longint amp);
        longint p;
        longint w;
        p = acc >> (PHASE_W - W);
        case (ws)
            0:       w = p;
            1:       w = (p >= 512) ? 1023 : 0;
            2:       w = (p < 512) ? 2 * p : 1023 - 2 * (p - 512);
            default: w = longint'(l >> 6);
        endcase
        return (((w * env) >> 16) * amp) >> 16;
    endfunction

    // Envelope updates land on every 4th clock edge after reset release.
    task automatic tick_step();
        int guard;
        guard = 0;
        @(negedge clk);
        while ((ecount % ENV_TICK) != 0 && guard < 16) begin
            @(negedge clk);
            guard++;
        end
    endtask

    typedef struct {
        logic        g;
        logic [15:0] atk;
        logic [15:0] dec;
        logic [15:0] sus;
        logic [15:0] rel;
        logic [15:0] lvl;
        int          st;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic g, input logic [15:0] a, input logic [15:0] d,
                       input logic [15:0] s, input logic [15:0] r,
                       input logic [15:0] lvl, input int st);
        vec_t v;
        v.g = g; v.atk = a; v.dec = d; v.sus = s; v.rel = r; v.lvl = lvl; v.st = st;
        tbl.push_back(v);
    endtask

    initial begin
        logic [15:0] dlv [7];
        logic [15:0] rlv [7];
        int          cnt;
        int          g;
        longint      inc;
        int          ws;
        longint      amp;
        longint      sus;
        longint      expv;

        rst = 1'b1; gate = 1'b0; phase_inc = '0; wave_sel = '0;
        attack_step = '0; decay_step = '0; release_step = '0; sustain_lvl = '0; amp_in = '0;

        dlv = '{16'hEFFF, 16'hDFFF, 16'hCFFF, 16'hBFFF, 16'hAFFF, 16'h9FFF, 16'h8FFF};
        rlv = '{16'hDFFF, 16'hBFFF, 16'h9FFF, 16'h7FFF, 16'h5FFF, 16'h3FFF, 16'h1FFF};
        add(1, 16'h4000, 16'h1000, 16'h8000, 16'h2000, 16'h4000, 1);
        add(1, 16'h4000, 16'h1000, 16'h8000, 16'h2000, 16'h8000, 1);
        add(1, 16'h4000, 16'h1000, 16'h8000, 16'h2000, 16'hC000, 1);
        add(1, 16'h4000, 16'h1000, 16'h8000, 16'h2000, 16'hFFFF, 2);
        for (int i = 0; i < 7; i++) add(1, 16'h4000, 16'h1000, 16'h8000, 16'h2000, dlv[i], 2);
        add(1, 16'h4000, 16'h1000, 16'h8000, 16'h2000, 16'h8000, 3);
        add(1, 16'h4000, 16'h1000, 16'h8000, 16'h2000, 16'h8000, 3);
        add(0, 16'h4000, 16'h1000, 16'h8000, 16'h2000, 16'h6000, 4);
        add(1, 16'h4000, 16'h1000, 16'h8000, 16'h2000, 16'hA000, 1);
        add(1, 16'h4000, 16'h1000, 16'h8000, 16'h2000, 16'hE000, 1);
        add(1, 16'h4000, 16'h1000, 16'h8000, 16'h2000, 16'hFFFF, 2);
        for (int i = 0; i < 7; i++) add(0, 16'h4000, 16'h1000, 16'h8000, 16'h2000, rlv[i], 4);
        add(0, 16'h4000, 16'h1000, 16'h8000, 16'h2000, 16'h0000, 0);
        add(0, 16'h4000, 16'h1000, 16'h8000, 16'h2000, 16'h0000, 0);
        add(1, 16'h0000, 16'h0000, 16'h3000, 16'h0000, 16'hFFFF, 2);
        add(1, 16'h0000, 16'h0000, 16'h3000, 16'h0000, 16'h3000, 3);
        add(1, 16'h0000, 16'h0000, 16'h5000, 16'h0000, 16'h5000, 3);
        add(0, 16'h0000, 16'h0000, 16'h5000, 16'h0000, 16'h0000, 0);

        repeat (2) @(negedge clk);
        check("reset_state", int'(eg_state), 0);
        check("reset_level", env_level, 0);
        check("reset_sample", sample, 0);
        check("reset_dout", dout, 0);
        check("reset_busy", busy, 0);
        rst = 1'b0;

        // Gate rise reaches eg_state three clocks later.
        tick_step();
        attack_step = 16'h4000; decay_step = 16'h1000; sustain_lvl = 16'h8000; release_step = 16'h0000;
        gate = 1'b1;
        @(negedge clk); check("gate_lat_clk1", int'(eg_state), 0);
        @(negedge clk); check("gate_lat_clk2", int'(eg_state), 0);
        @(negedge clk); check("gate_lat_clk3", int'(eg_state), 1);
        tick_step();    check("gate_lat_level", env_level, 16'h4000);
        gate = 1'b0;
        tick_step();
        check("rel_zero_step_level", env_level, 0);
        check("rel_zero_step_state", int'(eg_state), 0);

        foreach (tbl[i]) begin
            attack_step = tbl[i].atk; decay_step = tbl[i].dec;
            sustain_lvl = tbl[i].sus; release_step = tbl[i].rel;
            gate = tbl[i].g;
            tick_step();
            check($sformatf("tbl%0d_level", i), env_level, tbl[i].lvl);
            check($sformatf("tbl%0d_state", i), int'(eg_state), tbl[i].st);
            check($sformatf("tbl%0d_busy", i), busy, (tbl[i].st != 0) ? 1 : 0);
        end

        // Reset asserted in the middle of a release.
        attack_step = 16'h0000; decay_step = 16'h0000; sustain_lvl = 16'hC000; release_step = 16'h0100;
        amp_in = 16'hFFFF; wave_sel = 2'd0; phase_inc = 24'h010000; gate = 1'b1;
        tick_step(); tick_step(); tick_step();
        gate = 1'b0;
        tick_step();
        check("pre_reset_state", int'(eg_state), 4);
        check("pre_reset_level", env_level, 16'hBF00);
        rst = 1'b1;
        @(negedge clk);
        check("midrel_reset_state", int'(eg_state), 0);
        check("midrel_reset_level", env_level, 0);
        check("midrel_reset_sample", sample, 0);
        check("midrel_reset_dout", dout, 0);
        check("midrel_reset_busy", busy, 0);
        rst = 1'b0;
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            cnt += int'(dout);
        end
        check("idle_dout_highs", cnt, 0);
        check("idle_after_reset", int'(eg_state), 0);

        // Oscillator and scaling against the reference model, envelope parked in SUSTAIN.
        attack_step = 16'h0000; decay_step = 16'h0000; sustain_lvl = 16'h8000; gate = 1'b1;
        g = 0;
        while (eg_state != EG_SUSTAIN && g < 40) begin
            @(negedge clk);
            g++;
        end
        check("rand_enter_sustain", int'(eg_state), 3);
        for (int s = 0; s < 10; s++) begin
            @(negedge clk);
            if (s < 2) begin
                inc = 64'd16384; ws = s; amp = 64'h8000; sus = 64'h8000;
            end else begin
                inc = longint'($urandom & 32'h00FF_FFFF);
                ws  = int'($urandom_range(0, 3));
                amp = longint'($urandom & 32'hFFFF);
                sus = longint'($urandom & 32'hFFFF);
            end
            phase_inc = PHASE_W'(inc); wave_sel = 2'(ws);
            amp_in = 16'(amp); sustain_lvl = 16'(sus);
            repeat (10) @(negedge clk);
            check($sformatf("seg%0d_env", s), env_level, sus);
            for (int c = 0; c < 16; c++) begin
                expv = exp_sample(acc_h[2], lfsr_h[2], ws, sus, amp);
                check($sformatf("seg%0d_sample%0d", s, c), sample, expv);
                @(negedge clk);
            end
        end

        // PDM density with a held square-wave level.
        wave_sel = 2'd1; amp_in = 16'h4021; sustain_lvl = 16'hFFFF;
        phase_inc = PHASE_W'((PHASE_MOD + 64'hC00000 - m_acc) % PHASE_MOD);
        @(negedge clk);
        phase_inc = '0;
        repeat (12) @(negedge clk);
        check("pdm_sample_256", sample, 256);
        cnt = 0;
        repeat (1024) begin
            @(negedge clk);
            cnt += int'(dout);
        end
        check("pdm_density_256", cnt, 256);

        amp_in = 16'hFFFF;
        expv = exp_sample(m_acc, m_lfsr, 1, 64'hFFFF, 64'hFFFF);
        repeat (12) @(negedge clk);
        check("pdm_sample_full", sample, expv);
        cnt = 0;
        repeat (1024) begin
            @(negedge clk);
            cnt += int'(dout);
        end
        check("pdm_density_full", cnt, expv);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
